// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator
// and for the blocks that consume its coordinates.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned FCNT_W    = 16;
    localparam int unsigned MAX_TOTAL = 1024;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FCNT_W-1:0]  fcnt_t;

    // Default 640x480 at 60 Hz from a 50 MHz clock
    localparam int unsigned DEF_PIX_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return timing_total(act, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return timing_total(act, fp, sync, bp);
    endfunction

    // Sync window is [start, end): it opens right after the front porch
    function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
        return act + fp;
    endfunction

    function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync);
        return act + fp + sync;
    endfunction

    localparam int unsigned DEF_H_TOTAL    = h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL    = v_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int unsigned DEF_HS_START   = sync_start(DEF_H_ACTIVE, DEF_H_FP);
    localparam int unsigned DEF_HS_END     = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
    localparam int unsigned DEF_VS_START   = sync_start(DEF_V_ACTIVE, DEF_V_FP);
    localparam int unsigned DEF_VS_END     = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bus: advance enable in, coordinates/qualifiers/syncs out.
interface vga_sync_if;

    logic                          en;
    logic                          pix_en;
    vga_timing_pkg::coord_t        col;
    vga_timing_pkg::coord_t        row;
    logic                          active;
    logic                          vnotactive;
    logic                          hsync;
    logic                          vsync;
    logic                          frame_tick;
    vga_timing_pkg::fcnt_t         frame_cnt;

    modport master (
        input  en,
        output pix_en, col, row, active, vnotactive, hsync, vsync, frame_tick, frame_cnt
    );

    modport slave (
        output en,
        input  pix_en, col, row, active, vnotactive, hsync, vsync, frame_tick, frame_cnt
    );

endinterface

// File: rtl/vga_sync_pix_en_gen.sv
// Clock-enable divider: one registered pix_en strobe every DIV enabled cycles.
module pix_en_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pix_en
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] pdiv;
    logic [DW-1:0] pdiv_nxt;

    // Divider only moves while enabled, so a paused pipeline resumes in phase
    always_comb begin
        pdiv_nxt = pdiv;
        if (en) begin
            pdiv_nxt = (pdiv == LAST) ? '0 : pdiv + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdiv   <= '0;
            pix_en <= 1'b0;
        end else begin
            pdiv   <= pdiv_nxt;
            pix_en <= en && (pdiv_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel coordinates, blanking qualifiers,
// sync pulses and frame bookkeeping, all registered and mutually aligned.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    vga_sync_if.master bus
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam coord_t V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam coord_t H_LIM   = COORD_W'(H_ACTIVE);
    localparam coord_t V_LIM   = COORD_W'(V_ACTIVE);
    localparam coord_t HS_LO   = COORD_W'(sync_start(H_ACTIVE, H_FP));
    localparam coord_t HS_HI   = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam coord_t VS_LO   = COORD_W'(sync_start(V_ACTIVE, V_FP));
    localparam coord_t VS_HI   = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || PIX_DIV < 1) begin : g_bad_timing
        $error("vga_sync: totals must be <= 1024 and PIX_DIV >= 1");
    end

    pix_en_gen #(
        .DIV    (PIX_DIV)
    ) u_pix_en_gen (
        .clk    (CLK),
        .rst_n  (RST),
        .en     (bus.en),
        .pix_en (bus.pix_en)
    );

    coord_t col_nxt;
    coord_t row_nxt;
    fcnt_t  fcnt_nxt;
    logic   tick_nxt;

    // Next raster position; the frame boundary is the wrap of the last line
    always_comb begin
        col_nxt  = bus.col;
        row_nxt  = bus.row;
        fcnt_nxt = bus.frame_cnt;
        tick_nxt = 1'b0;
        if (bus.en && bus.pix_en) begin
            if (bus.col == H_LAST) begin
                col_nxt = '0;
                if (bus.row == V_LAST) begin
                    row_nxt  = '0;
                    fcnt_nxt = bus.frame_cnt + FCNT_W'(1);
                    tick_nxt = 1'b1;
                end else begin
                    row_nxt = bus.row + COORD_W'(1);
                end
            end else begin
                col_nxt = bus.col + COORD_W'(1);
            end
        end
    end

    // Qualifiers decode the next position so they line up with the coordinates
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.col        <= '0;
            bus.row        <= '0;
            bus.frame_cnt  <= '0;
            bus.frame_tick <= 1'b0;
            bus.active     <= 1'b1;
            bus.vnotactive <= 1'b0;
            bus.hsync      <= ~SYNC_POL;
            bus.vsync      <= ~SYNC_POL;
        end else begin
            bus.col        <= col_nxt;
            bus.row        <= row_nxt;
            bus.frame_cnt  <= fcnt_nxt;
            bus.frame_tick <= tick_nxt;
            bus.active     <= (col_nxt < H_LIM) && (row_nxt < V_LIM);
            bus.vnotactive <= (row_nxt >= V_LIM);
            bus.hsync      <= ((col_nxt >= HS_LO) && (col_nxt < HS_HI)) ? SYNC_POL : ~SYNC_POL;
            bus.vsync      <= ((row_nxt >= VS_LO) && (row_nxt < VS_HI)) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Randomized scoreboard bench for vga_sync on a reduced raster so several
// frames, pauses and a mid-frame reset fit in a short run.
module tb_vga_sync;

    localparam int PD  = 2;
    localparam int HA  = 16;
    localparam int HF  = 4;
    localparam int HS  = 6;
    localparam int HB  = 4;
    localparam int VA  = 10;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam bit POL = 1'b0;

    typedef struct {
        int cyc;
        int pix_en;
        int col;
        int row;
        int active;
        int vnot;
        int hs;
        int vs;
        int tick;
        int fcnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t q[$];

    // Reference model: linear pixel index within the frame plus divider phase
    int m_pdiv;
    int m_pos;
    int m_frames;
    bit m_pix;
    bit m_tick;

    vga_sync_if bus ();

    vga_sync #(
        .PIX_DIV  (PD),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic m_reset();
        m_pdiv   = 0;
        m_pos    = 0;
        m_frames = 0;
        m_pix    = 1'b0;
        m_tick   = 1'b0;
    endtask

    task automatic m_step(input bit e);
        if (e) begin
            m_tick = 1'b0;
            if (m_pix) begin
                m_pos = (m_pos + 1) % (HT * VT);
                if (m_pos == 0) begin
                    m_tick   = 1'b1;
                    m_frames = m_frames + 1;
                end
            end
            m_pdiv = (m_pdiv + 1) % PD;
            m_pix  = (m_pdiv == PD - 1);
        end else begin
            m_pix  = 1'b0;
            m_tick = 1'b0;
        end
    endtask

    function automatic exp_t mk(input int stamp);
        exp_t e;
        int   c;
        int   r;
        c        = m_pos % HT;
        r        = m_pos / HT;
        e.cyc    = stamp;
        e.pix_en = int'(m_pix);
        e.col    = c;
        e.row    = r;
        e.active = (c < HA && r < VA) ? 1 : 0;
        e.vnot   = (r >= VA) ? 1 : 0;
        e.hs     = (c >= HA + HF && c < HA + HF + HS) ? int'(POL) : int'(!POL);
        e.vs     = (r >= VA + VF && r < VA + VF + VS) ? int'(POL) : int'(!POL);
        e.tick   = int'(m_tick);
        e.fcnt   = m_frames % 65536;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    endtask

    // One clock of stimulus; r is the RST level applied just after the edge
    task automatic step(input bit e, input bit r);
        @(posedge CLK);
        #1;
        bus.en = e;
        if (RST && !r) begin
            RST = 1'b0;
            q.delete();
            m_reset();
            q.push_back(mk(cyc));
        end else begin
            RST = r;
        end
        if (!RST) m_reset();
        else m_step(e);
        q.push_back(mk(cyc + 1));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0 && q[0].cyc < cyc) begin
                chk("schedule", q[0].cyc, cyc);
                void'(q.pop_front());
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("pix_en",     int'(bus.pix_en),     e.pix_en);
                chk("col",        int'(bus.col),        e.col);
                chk("row",        int'(bus.row),        e.row);
                chk("active",     int'(bus.active),     e.active);
                chk("vnotactive", int'(bus.vnotactive), e.vnot);
                chk("hsync",      int'(bus.hsync),      e.hs);
                chk("vsync",      int'(bus.vsync),      e.vs);
                chk("frame_tick", int'(bus.frame_tick), e.tick);
                chk("frame_cnt",  int'(bus.frame_cnt),  e.fcnt);
            end
        end
    end

    initial begin : driver
        bus.en = 1'b0;
        m_reset();
        q.push_back(mk(1));
        repeat (4) step(1'b0, 1'b0);

        // Release and run the first lines
        step(1'b1, 1'b1);
        repeat (PD * HT * 3) step(1'b1, 1'b1);

        // Pause mid-line, then resume
        for (int i = 0; i < 200 && (m_pos % HT) != 12; i++) step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);

        // Through vertical blanking and the first frame wrap
        repeat (PD * HT * VT + 100) step(1'b1, 1'b1);

        // Random enable pattern
        repeat (1200) step($urandom_range(0, 3) != 0, 1'b1);

        // Asynchronous reset mid-frame, then a full frame from (0,0)
        for (int i = 0; i < 3000 && m_pos != 7 * HT + 12; i++) step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (PD * HT * VT + 60) step(1'b1, 1'b1);

        @(negedge CLK);
        @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Raster timing generator that sits directly upstream of the pixel-colour/display stage.
- Produces the pixel coordinates (row, col), the blanking qualifiers (active, vnotactive) and the VGA sync pulses.
- Consumers use row/col to pick pixel colour, and vnotactive to time once-per-frame key sampling.
- Default timing is 640x480 at 60 Hz from a 50 MHz CLK, using an internal divide-by-2 pixel enable.

Parameters:
- PIX_DIV, 2: CLK cycles per pixel; must be >= 1. With PIX_DIV=1, pix_en is permanently high.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync asserted level (0 = active-low pulses).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- en  in  1  timing advance enable; when low, all state freezes.
- pix_en  out  1  one-CLK strobe marking each pixel advance.
- col  out  10  current horizontal count, 0..H_TOTAL-1.
- row  out  10  current vertical count, 0..V_TOTAL-1.
- active  out  1  high when col<H_ACTIVE and row<V_ACTIVE.
- vnotactive  out  1  high when row>=V_ACTIVE (vertical blanking).
- hsync  out  1  horizontal sync pulse.
- vsync  out  1  vertical sync pulse.
- frame_tick  out  1  one-CLK pulse on the transition to (row,col)=(0,0).
- frame_cnt  out  16  count of completed frames, wraps.

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset (RST low, asynchronous):
  - internal divider pdiv=0; col=0; row=0; frame_cnt=0.
  - pix_en=0; frame_tick=0; active=1; vnotactive=0.
  - hsync=vsync=~SYNC_POL.
  - All outputs are flip-flop driven.
- Pixel enable:
  - pdiv counts 0..PIX_DIV-1 while en=1.
  - pix_en=1 during the CLK cycle in which pdiv==PIX_DIV-1; pdiv wraps to 0 on the following edge.
- Counter advance (on a CLK edge where en=1 and pix_en=1):
  - col increments.
  - When col==H_TOTAL-1, col wraps to 0 and row increments.
  - When row==V_TOTAL-1 at that wrap, row wraps to 0 and frame_cnt increments (modulo 2^16).
- en=0: pdiv, col, row, frame_cnt and all decoded outputs hold their values; pix_en=0; frame_tick=0.
- Decoded outputs:
  - Registered and computed from next-state counter values, so on every cycle they are consistent with the row/col presented on that cycle. There is zero lag between coordinates and qualifiers.
  - hsync=SYNC_POL iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync=SYNC_POL iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - vsync transitions only at a col wrap.
- frame_tick:
  - High for exactly one CLK: the cycle in which row=0, col=0 is first presented after the wrap.
  - Not asserted coming out of reset.
- Width rules:
  - All counter compares are unsigned, 10-bit.
  - H_TOTAL and V_TOTAL must be <= 1024; this is elaboration-time checked.
- Reset mid-frame: immediate return to the reset values above. The first frame after release is a full frame starting at (0,0).
- Frame period: H_TOTAL*V_TOTAL*PIX_DIV CLK cycles (840000 by default).

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60;
  - derived H_TOTAL/V_TOTAL functions;
  - the sync-window bound constants.
- One sub-module, pix_en_gen, is natural: it is the pdiv counter with en gating and pix_en output, and it is reused by other clock-enabled blocks in the design.

Test Plan:
- Reset release, defaults:
  - pix_en pulses every 2nd CLK.
  - col steps 0,1,2,… once per pix_en.
  - The first hsync falling edge occurs when col reaches 656; hsync rises when col reaches 752.
- Line wrap: at col=799 plus one pix_en, col=0 and row increments by 1. Line period is 1600 CLK.
- Vertical blanking:
  - vnotactive rises on the cycle row becomes 480.
  - vsync is low exactly for rows 490 and 491 (3200 CLK).
  - active=0 throughout the vertical blanking.
- Frame wrap:
  - After 840000 CLK, frame_tick pulses for one cycle with row=col=0 and frame_cnt=1.
  - No frame_tick occurs at reset release.
- en held low for 100 CLK mid-line (e.g. at col=300):
  - row, col, hsync and vsync are frozen; pix_en=0.
  - Resuming continues from col=300 with no skip.
- RST asserted at row=200, col=400:
  - Outputs reach reset values asynchronously.
  - After release, the sequence restarts at (0,0); frame_cnt=0.
